// File: rtl/mbtrain_repair_responder.sv
// Partner-side responder for the MBTRAIN REPAIR handshake: answers the
// init / apply-degrade / end requests, latches the partner lane status
// carried by the degrade request, and guards every wait with a timeout.
module mbtrain_repair_responder #(
  parameter logic [3:0]  MSG_INIT_REQ     = 4'd1,
  parameter logic [3:0]  MSG_INIT_RESP    = 4'd2,
  parameter logic [3:0]  MSG_DEGRADE_REQ  = 4'd3,
  parameter logic [3:0]  MSG_DEGRADE_RESP = 4'd4,
  parameter logic [3:0]  MSG_END_REQ      = 4'd5,
  parameter logic [3:0]  MSG_END_RESP     = 4'd6,
  parameter logic [15:0] TIMEOUT_CYCLES   = 16'd8000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_sideband_message,
  input  logic       i_sideband_valid,
  input  logic [2:0] i_sideband_data_lanes_encoding,
  input  logic       i_falling_edge_busy,
  output logic       o_valid,
  output logic [3:0] o_sideband_message,
  output logic       o_remote_partner_first_8_lanes_result,
  output logic       o_remote_partner_second_8_lanes_result,
  output logic       o_test_ack,
  output logic       o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_SEND_INIT,
    S_WAIT_DEGRADE,
    S_SEND_DEGRADE,
    S_WAIT_END,
    S_SEND_END,
    S_DONE
  } state_t;

  localparam logic [15:0 ] W_LAST = TIMEOUT_CYCLES - 16'd1;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic        r_valid;
  logic [3:0]  r_msg;
  logic        r_first;
  logic        r_second;
  logic        r_timeout;

  logic        w_in_wait;
  logic        w_expired;
  logic        w_strobe;
  logic [3:0]  w_resp;
  logic        w_latch;
  logic        w_set_timeout;
  logic        w_busy_done;

  assign w_expired   = (r_cnt == W_LAST);
  // The strobe cycle is the first cycle in SEND_x; a busy pulse then is stale.
  assign w_busy_done = i_falling_edge_busy && !r_valid;

  // Next-state decode, response selection and timeout detection.
  always_comb begin
    w_next        = r_state;
    w_in_wait     = 1'b0;
    w_strobe      = 1'b0;
    w_resp        = '0;
    w_latch       = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_WAIT_INIT;
      S_WAIT_INIT: begin
        w_in_wait = 1'b1;
        if (i_sideband_valid && i_sideband_message == MSG_INIT_REQ) begin
          w_next   = S_SEND_INIT;
          w_strobe = 1'b1;
          w_resp   = MSG_INIT_RESP;
        end else if (w_expired) begin
          w_next        = S_DONE;
          w_set_timeout = 1'b1;
        end
      end
      S_SEND_INIT: if (w_busy_done) w_next = S_WAIT_DEGRADE;
      S_WAIT_DEGRADE: begin
        w_in_wait = 1'b1;
        if (i_sideband_valid && i_sideband_message == MSG_DEGRADE_REQ) begin
          w_next   = S_SEND_DEGRADE;
          w_strobe = 1'b1;
          w_resp   = MSG_DEGRADE_RESP;
          w_latch  = 1'b1;
        end else if (w_expired) begin
          w_next        = S_DONE;
          w_set_timeout = 1'b1;
        end
      end
      S_SEND_DEGRADE: if (w_busy_done) w_next = S_WAIT_END;
      S_WAIT_END: begin
        w_in_wait = 1'b1;
        if (i_sideband_valid && i_sideband_message == MSG_END_REQ) begin
          w_next   = S_SEND_END;
          w_strobe = 1'b1;
          w_resp   = MSG_END_RESP;
        end else if (i_sideband_valid && i_sideband_message == MSG_DEGRADE_REQ) begin
          w_next   = S_SEND_DEGRADE;
          w_strobe = 1'b1;
          w_resp   = MSG_DEGRADE_RESP;
          w_latch  = 1'b1;
        end else if (w_expired) begin
          w_next        = S_DONE;
          w_set_timeout = 1'b1;
        end
      end
      S_SEND_END: if (w_busy_done) w_next = S_DONE;
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (!i_en) begin
      w_next        = S_IDLE;
      w_strobe      = 1'b0;
      w_resp        = '0;
      w_latch       = 1'b0;
      w_set_timeout = 1'b0;
    end
  end

  // State, wait counter, response strobe, lane status and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_msg     <= '0;
      r_first   <= 1'b0;
      r_second  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_in_wait && w_next == r_state) ? r_cnt + 16'd1 : '0;
      r_valid <= w_strobe;
      r_msg   <= w_strobe ? w_resp : '0;
      if (w_latch) begin
        r_first  <= (i_sideband_data_lanes_encoding == 3'b011) ||
                    (i_sideband_data_lanes_encoding == 3'b001);
        r_second <= (i_sideband_data_lanes_encoding == 3'b011) ||
                    (i_sideband_data_lanes_encoding == 3'b010);
      end
      if (!i_en)              r_timeout <= 1'b0;
      else if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  assign o_valid                                = r_valid;
  assign o_sideband_message                     = r_msg;
  assign o_remote_partner_first_8_lanes_result  = r_first;
  assign o_remote_partner_second_8_lanes_result = r_second;
  assign o_test_ack                             = (r_state == S_DONE) && !r_timeout;
  assign o_timeout                              = r_timeout;

endmodule

// File: tb/tb_mbtrain_repair_responder.sv
// Bench for mbtrain_repair_responder: directed table, hand-written corner
// sequences, then random traffic against a phase-level protocol model.
module tb_mbtrain_repair_responder;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;
  localparam int   TO = 16;
  localparam logic [3:0] INIT_REQ = 4'd1;
  localparam logic [3:0] DEG_REQ  = 4'd3;
  localparam logic [3:0] END_REQ  = 4'd5;

  logic       clk;
  logic       rst;
  logic       i_en;
  logic [3:0] i_sideband_message;
  logic       i_sideband_valid;
  logic [2:0] i_sideband_data_lanes_encoding;
  logic       i_falling_edge_busy;
  logic       o_valid;
  logic [3:0] o_sideband_message;
  logic       o_first;
  logic       o_second;
  logic       o_test_ack;
  logic       o_timeout;

  mbtrain_repair_responder #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk                                    (clk),
    .rst                                    (rst),
    .i_en                                   (i_en),
    .i_sideband_message                     (i_sideband_message),
    .i_sideband_valid                       (i_sideband_valid),
    .i_sideband_data_lanes_encoding         (i_sideband_data_lanes_encoding),
    .i_falling_edge_busy                    (i_falling_edge_busy),
    .o_valid                                (o_valid),
    .o_sideband_message                     (o_sideband_message),
    .o_remote_partner_first_8_lanes_result  (o_first),
    .o_remote_partner_second_8_lanes_result (o_second),
    .o_test_ack                             (o_test_ack),
    .o_timeout                              (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Strobe monitor: counts every emitted response per code.
  int n_str [16];
  initial for (int k = 0; k < 16; k++) n_str[k] = 0;
  always @(negedge clk) if (o_valid === 1'b1) n_str[o_sideband_message] = n_str[o_sideband_message] + 1;

  function automatic int str_total();
    int s = 0;
    for (int k = 0; k < 16; k++) s += n_str[k];
    return s;
  endfunction

  typedef struct {
    logic       rst, en;
    logic [3:0] msg;
    logic       vld;
    logic [2:0] enc;
    logic       busy;
    logic       e_v;
    logic [3:0] e_m;
    logic       e_f, e_s, e_a, e_t;
  } vec_t;

  function automatic vec_t mk(input logic r, e, input logic [3:0] m, input logic v,
                              input logic [2:0] enc, input logic b,
                              input logic ev, input logic [3:0] em,
                              input logic ef, es, ea, et);
    vec_t x;
    x.rst = r; x.en = e; x.msg = m; x.vld = v; x.enc = enc; x.busy = b;
    x.e_v = ev; x.e_m = em; x.e_f = ef; x.e_s = es; x.e_a = ea; x.e_t = et;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [3:0] em,
                         input logic ef, es, ea, et);
    chk({nm, ".valid"},  {3'b0, o_valid},    {3'b0, ev});
    chk({nm, ".msg"},    o_sideband_message, em);
    chk({nm, ".first"},  {3'b0, o_first},    {3'b0, ef});
    chk({nm, ".second"}, {3'b0, o_second},   {3'b0, es});
    chk({nm, ".ack"},    {3'b0, o_test_ack}, {3'b0, ea});
    chk({nm, ".tmo"},    {3'b0, o_timeout},  {3'b0, et});
  endtask

  task automatic tick(input logic r, e, input logic [3:0] m, input logic v,
                      input logic [2:0] enc, input logic b);
    rst = r; i_en = e; i_sideband_message = m; i_sideband_valid = v;
    i_sideband_data_lanes_encoding = enc; i_falling_edge_busy = b;
    @(posedge clk);
    #1;
  endtask

  // Protocol model: which of the three requests is awaited, whether its
  // response is outstanding, and how long the current wait has lasted.
  int   m_phase, m_waited;
  logic m_active, m_done, m_to, m_answering, m_fresh, m_f, m_s;

  function automatic logic [3:0] req_of(input int p);
    return (p == 0) ? INIT_REQ : (p == 1) ? DEG_REQ : END_REQ;
  endfunction
  function automatic logic [3:0] resp_of(input int p);
    return (p == 0) ? 4'd2 : (p == 1) ? 4'd4 : 4'd6;
  endfunction

  task automatic model_step(input logic r, e, input logic [3:0] m, input logic v,
                            input logic [2:0] enc, input logic b);
    logic hit;
    if (r) begin
      m_active = 0; m_done = 0; m_to = 0; m_answering = 0; m_fresh = 0;
      m_f = 0; m_s = 0; m_waited = 0; m_phase = 0;
    end else if (!e) begin
      m_active = 0; m_fresh = 0; m_to = 0; m_done = 0;
    end else if (!m_active) begin
      m_active = 1; m_phase = 0; m_answering = 0; m_waited = 0;
      m_done = 0; m_fresh = 0; m_to = 0;
    end else if (m_done) begin
      m_fresh = 0;
    end else if (m_answering) begin
      if (!m_fresh && b) begin
        m_phase++;
        m_answering = 0;
        m_waited = 0;
        if (m_phase == 3) m_done = 1;
      end
      m_fresh = 0;
    end else begin
      hit = v && ((m == req_of(m_phase)) || (m_phase == 2 && m == DEG_REQ));
      if (hit) begin
        if (m == DEG_REQ) begin
          m_f = (enc == 3'd3) || (enc == 3'd1);
          m_s = (enc == 3'd3) || (enc == 3'd2);
          m_phase = 1;
        end
        m_answering = 1;
        m_fresh = 1;
      end else if (m_waited == TO - 1) begin
        m_to = 1;
        m_done = 1;
      end else begin
        m_waited++;
      end
    end
  endtask

  vec_t tbl [19];

  initial begin
    int snap;
    int vprob;
    logic r, e, v, b;
    logic [3:0] m;
    logic [2:0] enc;

    // Full sequence with stale-busy checks, then wrong-code-in-WAIT_INIT.
    tbl[0]  = mk(L1, L0, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L0, L0, L0, L0);
    tbl[1]  = mk(L0, L1, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L0, L0, L0, L0);
    tbl[2]  = mk(L0, L1, 4'd1, L1, 3'd0, L0,  L1, 4'd2, L0, L0, L0, L0);
    tbl[3]  = mk(L0, L1, 4'd0, L0, 3'd0, L1,  L0, 4'd0, L0, L0, L0, L0);
    tbl[4]  = mk(L0, L1, 4'd0, L0, 3'd0, L1,  L0, 4'd0, L0, L0, L0, L0);
    tbl[5]  = mk(L0, L1, 4'd3, L1, 3'd3, L0,  L1, 4'd4, L1, L1, L0, L0);
    tbl[6]  = mk(L0, L1, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L1, L1, L0, L0);
    tbl[7]  = mk(L0, L1, 4'd0, L0, 3'd0, L1,  L0, 4'd0, L1, L1, L0, L0);
    tbl[8]  = mk(L0, L1, 4'd5, L1, 3'd0, L0,  L1, 4'd6, L1, L1, L0, L0);
    tbl[9]  = mk(L0, L1, 4'd0, L0, 3'd0, L1,  L0, 4'd0, L1, L1, L0, L0);
    tbl[10] = mk(L0, L1, 4'd0, L0, 3'd0, L1,  L0, 4'd0, L1, L1, L1, L0);
    tbl[11] = mk(L0, L1, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L1, L1, L1, L0);
    tbl[12] = mk(L0, L0, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L1, L1, L0, L0);
    tbl[13] = mk(L0, L1, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L1, L1, L0, L0);
    tbl[14] = mk(L0, L1, 4'd5, L1, 3'd0, L0,  L0, 4'd0, L1, L1, L0, L0);
    tbl[15] = mk(L0, L1, 4'd1, L1, 3'd0, L0,  L1, 4'd2, L1, L1, L0, L0);
    tbl[16] = mk(L0, L1, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L1, L1, L0, L0);
    tbl[17] = mk(L0, L1, 4'd1, L1, 3'd0, L0,  L0, 4'd0, L1, L1, L0, L0);
    tbl[18] = mk(L0, L0, 4'd0, L0, 3'd0, L0,  L0, 4'd0, L1, L1, L0, L0);

    rst = 1'b1; i_en = 1'b0; i_sideband_message = '0; i_sideband_valid = 1'b0;
    i_sideband_data_lanes_encoding = '0; i_falling_edge_busy = 1'b0;

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].rst, tbl[i].en, tbl[i].msg, tbl[i].vld, tbl[i].enc, tbl[i].busy);
      chk_out($sformatf("tbl%0d", i), tbl[i].e_v, tbl[i].e_m, tbl[i].e_f,
              tbl[i].e_s, tbl[i].e_a, tbl[i].e_t);
    end

    // Repeated degrade request: encodings 010 then 001, two DEGRADE_RESP.
    tick(L1, L0, 4'd0, L0, 3'd0, L0);
    chk_out("rdeg.reset", L0, 4'd0, L0, L0, L0, L0);
    snap = n_str[4];
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, INIT_REQ, L1, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L1);
    tick(L0, L1, DEG_REQ, L1, 3'd2, L0);
    chk_out("rdeg.first", L1, 4'd4, L0, L1, L0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L1);
    tick(L0, L1, DEG_REQ, L1, 3'd1, L0);
    chk_out("rdeg.second", L1, 4'd4, L1, L0, L0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L1);
    tick(L0, L1, END_REQ, L1, 3'd0, L0);
    chk_out("rdeg.end", L1, 4'd6, L1, L0, L0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L1);
    chk_out("rdeg.done", L0, 4'd0, L1, L0, L1, L0);
    chk("rdeg.count", 4'(n_str[4] - snap), 4'd2);

    // Timeout in WAIT_INIT after exactly 16 waiting cycles.
    tick(L1, L0, 4'd0, L0, 3'd0, L0);
    snap = str_total();
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    for (int k = 0; k < TO - 1; k++) tick(L0, L1, 4'd0, L0, 3'd0, L0);
    chk_out("tmo.before", L0, 4'd0, L0, L0, L0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    chk_out("tmo.hit", L0, 4'd0, L0, L0, L0, L1);
    tick(L0, L1, INIT_REQ, L1, 3'd0, L1);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    chk_out("tmo.sticky", L0, 4'd0, L0, L0, L0, L1);
    chk("tmo.nostrobe", 4'(str_total() - snap), 4'd0);
    tick(L0, L0, 4'd0, L0, 3'd0, L0);
    chk_out("tmo.clear", L0, 4'd0, L0, L0, L0, L0);

    // Request on the expiry cycle wins over the timeout.
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    for (int k = 0; k < TO - 1; k++) tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, INIT_REQ, L1, 3'd0, L0);
    chk_out("prio", L1, 4'd2, L0, L0, L0, L0);

    // Reset in SEND_DEGRADE abandons the sequence.
    tick(L1, L0, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, INIT_REQ, L1, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L0);
    tick(L0, L1, 4'd0, L0, 3'd0, L1);
    tick(L0, L1, DEG_REQ, L1, 3'd3, L0);
    chk_out("rst.deg", L1, 4'd4, L1, L1, L0, L0);
    tick(L1, L1, 4'd0, L0, 3'd0, L1);
    chk_out("rst.mid", L0, 4'd0, L0, L0, L0, L0);
    snap = str_total();
    for (int k = 0; k < 3; k++) tick(L0, L1, 4'd0, L0, 3'd0, L1);
    chk_out("rst.after", L0, 4'd0, L0, L0, L0, L0);
    chk("rst.nostrobe", 4'(str_total() - snap), 4'd0);

    // Random traffic against the model.
    tick(L1, L0, 4'd0, L0, 3'd0, L0);
    model_step(L1, L0, 4'd0, L0, 3'd0, L0);
    vprob = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) vprob = ($urandom_range(0, 1) == 0) ? 4 : 45;
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) >= 3);
      v = ($urandom_range(0, 99) < vprob);
      case ($urandom_range(0, 3))
        0: m = INIT_REQ;
        1: m = DEG_REQ;
        2: m = END_REQ;
        default: m = 4'($urandom_range(0, 15));
      endcase
      enc = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 99) < 40);
      model_step(r, e, m, v, enc, b);
      tick(r, e, m, v, enc, b);
      chk_out($sformatf("rnd%0d", c), m_fresh, m_fresh ? resp_of(m_phase) : 4'd0,
              m_f, m_s, m_done && !m_to, m_to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mbtrain_repair_responder.md
MBTRAIN_REPAIR_RESPONDER -- requirements
Module: mbtrain_repair_responder

Interface
REQ-001 SHALL have parameter MSG_INIT_REQ, default 4'd1, meaning REPAIR init request code.
REQ-002 SHALL have parameter MSG_INIT_RESP, default 4'd2, meaning REPAIR init response code.
REQ-003 SHALL have parameter MSG_DEGRADE_REQ, default 4'd3, meaning apply-degrade request code (carries lane encoding).
REQ-004 SHALL have parameter MSG_DEGRADE_RESP, default 4'd4, meaning apply-degrade response code.
REQ-005 SHALL have parameter MSG_END_REQ, default 4'd5, meaning REPAIR end request code.
REQ-006 SHALL have parameter MSG_END_RESP, default 4'd6, meaning REPAIR end response code.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 16'd8000, meaning max cycles waiting in any WAIT state.
REQ-008 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-009 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-010 SHALL have port i_en  input  1  enable from MBTRAIN; low forces IDLE.
REQ-011 SHALL have port i_sideband_message  input  4  received sideband message code.
REQ-012 SHALL have port i_sideband_valid  input  1  one-cycle strobe qualifying received message.
REQ-013 SHALL have port i_sideband_data_lanes_encoding  input  3  lane encoding received with degrade request.
REQ-014 SHALL have port i_falling_edge_busy  input  1  one-cycle pulse: sideband finished sending last message.
REQ-015 SHALL have port o_valid  output  1  one-cycle strobe qualifying o_sideband_message.
REQ-016 SHALL have port o_sideband_message  output  4  message code to send.
REQ-017 SHALL have ports o_remote_partner_first_8_lanes_result / o_remote_partner_second_8_lanes_result  output  1 each  decoded partner lane status.
REQ-018 SHALL have port o_test_ack  output  1  held high in DONE after successful sequence.
REQ-019 SHALL have port o_timeout  output  1  sticky error, set on wait-state expiry.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_INIT, SEND_INIT, WAIT_DEGRADE, SEND_DEGRADE, WAIT_END, SEND_END, DONE.
REQ-021 SHALL move IDLE->WAIT_INIT the cycle after i_en is sampled high.
REQ-022 SHALL move WAIT_x->SEND_x when i_sideband_valid=1 and message equals the matching request code; other codes or valid=0 leave state unchanged.
REQ-023 SHALL, on entry to SEND_x, drive o_valid=1 for exactly one cycle with the matching response code on o_sideband_message; o_sideband_message SHALL be 4'b0000 when o_valid=0.
REQ-024 SHALL remain in SEND_x after the strobe until i_falling_edge_busy=1, then move to next WAIT (SEND_INIT->WAIT_DEGRADE, SEND_DEGRADE->WAIT_END) or SEND_END->DONE.
REQ-025 SHALL ignore i_falling_edge_busy in the same cycle as the o_valid strobe.
REQ-026 SHALL latch lane encoding when the degrade request is accepted: 3'b011 -> results 1/1; 3'b001 -> 1/0; 3'b010 -> 0/1; all other codes -> 0/0.
REQ-027 SHALL accept a repeated degrade request in WAIT_END (relatch encoding, re-enter SEND_DEGRADE).
REQ-028 SHALL assert o_test_ack=1 in DONE only while o_timeout=0; hold DONE until i_en=0.
REQ-029 SHALL count cycles in each WAIT state with a 16-bit counter cleared on every state change; when count reaches TIMEOUT_CYCLES-1 without a matching request, set o_timeout and go to DONE.
REQ-030 SHALL give a matching request priority over timeout expiry in the same cycle.
REQ-031 SHALL, when i_en=0 in any state, go to IDLE next cycle, clearing o_valid, o_test_ack, o_timeout, counter; lane results hold their last value.
REQ-032 SHALL not emit o_valid in IDLE, WAIT_x or DONE.

Reset
REQ-033 SHALL, while rst=1 (priority over i_en), force IDLE, o_valid=0, o_sideband_message=0, both lane results=0, o_test_ack=0, o_timeout=0, counter=0.
REQ-034 SHALL, on rst mid-sequence, abandon the sequence without emitting any further response.

Verification
REQ-035 Full sequence: i_en=1; INIT_REQ, busy-fall; DEGRADE_REQ enc 3'b011, busy-fall; END_REQ, busy-fall -> responses 2,4,6 one strobe each; results 1/1; o_test_ack=1.
REQ-036 Degrade enc 3'b010 then repeated with 3'b001 before END_REQ -> two DEGRADE_RESP strobes; final results 1/0.
REQ-037 No request for TIMEOUT_CYCLES=16 in WAIT_INIT -> o_timeout=1 at cycle 16, o_test_ack=0, no o_valid.
REQ-038 Wrong code (END_REQ) in WAIT_INIT then INIT_REQ -> only INIT_RESP emitted; FSM advances once.
REQ-039 rst=1 in SEND_DEGRADE before busy-fall -> next cycle all outputs 0, state IDLE; i_en low in DONE -> o_test_ack drops next cycle.
